fila_input_ctrl: RTL and testbench

Upstream front end for the 8-entry queue. It turns raw push-buttons and data switches (10 kHz clock domain) into clean, single-cycle, mutually exclusive enqueue/dequeue strobes plus a stable data byte. It blocks requests that would overflow or underflow the queue, using the queue's length output as feedback, and flags rejected requests for the user.

---
 rtl/fila_input_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fila_input_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fila_input_ctrl.sv
// Queue front end: sync, debounce and edge-detect two push-buttons and issue
// single-cycle, mutually exclusive enqueue/dequeue strobes guarded by len_in.
//
// Ports:
//   clk_10KHz    system clock
//   reset        asynchronous, active-high
//   btn_enq_raw  raw enqueue button
//   btn_deq_raw  raw dequeue button
//   sw_data      data switches, latched on an accepted enqueue
//   len_in       queue occupancy fed back from the queue
//   enqueue_out  one-cycle enqueue strobe
//   dequeue_out  one-cycle dequeue strobe
//   data_out     byte presented to the queue
//   err_full     sticky: last enqueue rejected, queue full
//   err_empty    sticky: last dequeue rejected, queue empty
module fila_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPTH           = 8,
    parameter int DATA_W          = 8
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              btn_enq_raw,
    input  logic              btn_deq_raw,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [7:0]        len_in,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              err_full,
    output logic              err_empty
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_REL
    } state_t;

    state_t state, state_n;

    // Index 0 is the enqueue button, index 1 the dequeue button.
    logic [1:0]    raw;
    logic [1:0]    s1, s2;
    logic [1:0]    lvl, lvl_q;
    logic [1:0]    arm;
    logic [1:0]    rise;
    logic [CW-1:0] cnt  [2];
    logic [CW-1:0] lcnt [2];

    logic              enq_n, deq_n;
    logic [DATA_W-1:0] data_n;
    logic              ef_n, ee_n;
    logic              full, empty;

    assign raw = {btn_deq_raw, btn_enq_raw};

    // A button held through reset must be seen released (synced low for
    // DEBOUNCE_CYCLES cycles) before its rising edge can count as a request.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            arm   <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i]  <= '0;
                lcnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    lvl[i] <= ~lvl[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end

                if (s2[i]) begin
                    lcnt[i] <= '0;
                end else if (!arm[i]) begin
                    if (lcnt[i] == CNT_LAST) arm[i] <= 1'b1;
                    lcnt[i] <= lcnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise  = lvl & ~lvl_q & arm;
    assign full  = (len_in >= 8'(DEPTH));
    assign empty = (len_in == 8'd0);

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            data_out    <= '0;
            err_full    <= 1'b0;
            err_empty   <= 1'b0;
        end else begin
            state       <= state_n;
            enqueue_out <= enq_n;
            dequeue_out <= deq_n;
            data_out    <= data_n;
            err_full    <= ef_n;
            err_empty   <= ee_n;
        end
    end

    always_comb begin
        state_n = state;
        enq_n   = 1'b0;
        deq_n   = 1'b0;
        data_n  = data_out;
        ef_n    = err_full;
        ee_n    = err_empty;
        unique case (state)
            IDLE: begin
                // Enqueue wins; a simultaneous dequeue edge is dropped.
                if (rise[0]) begin
                    if (!full) begin
                        data_n  = sw_data;
                        enq_n   = 1'b1;
                        ef_n    = 1'b0;
                        ee_n    = 1'b0;
                        state_n = ISSUE;
                    end else begin
                        ef_n    = 1'b1;
                        state_n = WAIT_REL;
                    end
                end else if (rise[1]) begin
                    if (!empty) begin
                        deq_n   = 1'b1;
                        ef_n    = 1'b0;
                        ee_n    = 1'b0;
                        state_n = ISSUE;
                    end else begin
                        ee_n    = 1'b1;
                        state_n = WAIT_REL;
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT_REL;
            end
            WAIT_REL: begin
                if (lvl == 2'b00) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fila_input_ctrl.sv
// Scoreboard bench for fila_input_ctrl: press operations predict strobes,
// a negedge monitor pops and compares every strobe the DUT presents.
module tb_fila_input_ctrl;

    localparam int D     = 4;
    localparam int DEPTH = 8;

    logic       clk_10KHz = 1'b0;
    logic       reset;
    logic       btn_enq_raw, btn_deq_raw;
    logic [7:0] sw_data, len_in;
    logic       enqueue_out, dequeue_out;
    logic [7:0] data_out;
    logic       err_full, err_empty;

    fila_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .DEPTH(DEPTH),
        .DATA_W(8)
    ) dut (
        .clk_10KHz(clk_10KHz),
        .reset(reset),
        .btn_enq_raw(btn_enq_raw),
        .btn_deq_raw(btn_deq_raw),
        .sw_data(sw_data),
        .len_in(len_in),
        .enqueue_out(enqueue_out),
        .dequeue_out(dequeue_out),
        .data_out(data_out),
        .err_full(err_full),
        .err_empty(err_empty)
    );

    always #5 clk_10KHz = ~clk_10KHz;

    typedef struct {
        bit       is_deq;
        bit [7:0] data;
        int       cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    bit       m_ef, m_ee;
    bit [7:0] m_data;

    always @(posedge clk_10KHz) cyc <= cyc + 1;

    always @(negedge clk_10KHz) begin
        if (!reset) begin
            if (enqueue_out && dequeue_out) begin
                tests++;
                fails++;
                $display("FAIL excl: both strobes high at cyc %0d", cyc);
            end
            if (enqueue_out || dequeue_out) begin
                exp_t e;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL strobe: unexpected enq=%0b deq=%0b at cyc %0d",
                             enqueue_out, dequeue_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (dequeue_out != e.is_deq || cyc != e.cyc ||
                        (!e.is_deq && data_out != e.data)) begin
                        fails++;
                        $display("FAIL strobe: got deq=%0b cyc=%0d data=%h, want deq=%0b cyc=%0d data=%h",
                                 dequeue_out, cyc, data_out, e.is_deq, e.cyc, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic predict(input bit pe, input bit pd, input int hold,
                           input bit [7:0] len, input bit [7:0] d, input int t0);
        exp_t e;
        if (hold < D) return;
        if (pe) begin
            if (len < DEPTH) begin
                e.is_deq = 0;
                e.data   = d;
                e.cyc    = t0 + D + 3;
                exp_q.push_back(e);
                m_data = d;
                m_ef   = 0;
                m_ee   = 0;
            end else begin
                m_ef = 1;
            end
        end else if (pd) begin
            if (len > 0) begin
                e.is_deq = 1;
                e.data   = 0;
                e.cyc    = t0 + D + 3;
                exp_q.push_back(e);
                m_ef = 0;
                m_ee = 0;
            end else begin
                m_ee = 1;
            end
        end
    endtask

    task automatic do_op(input bit pe, input bit pd, input int hold,
                         input bit [7:0] len, input bit [7:0] d);
        int t0;
        len_in  = len;
        sw_data = d;
        @(negedge clk_10KHz);
        t0 = cyc;
        btn_enq_raw = pe;
        btn_deq_raw = pd;
        predict(pe, pd, hold, len, d, t0);
        repeat (hold) @(negedge clk_10KHz);
        btn_enq_raw = 0;
        btn_deq_raw = 0;
        repeat (D + 8) @(negedge clk_10KHz);
        check("err_full", int'(err_full), int'(m_ef));
        check("err_empty", int'(err_empty), int'(m_ee));
        check("data_out", int'(data_out), int'(m_data));
    endtask

    initial begin
        bit seen;
        reset       = 1;
        btn_enq_raw = 0;
        btn_deq_raw = 0;
        sw_data     = 0;
        len_in      = 0;
        m_ef = 0;
        m_ee = 0;
        m_data = 0;
        repeat (3) @(negedge clk_10KHz);
        check("rst_enq", int'(enqueue_out), 0);
        check("rst_deq", int'(dequeue_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_flags", int'({err_full, err_empty}), 0);
        reset = 0;
        repeat (D + 4) @(negedge clk_10KHz);

        do_op(1, 0, 20, 0, 8'hA5);
        do_op(0, 1, 3, 5, 8'h00);
        do_op(1, 0, 8, 8, 8'h11);
        do_op(0, 1, 8, 3, 8'h22);
        do_op(0, 1, 8, 0, 8'h33);
        do_op(1, 0, 8, 0, 8'h3C);
        do_op(1, 1, 8, 4, 8'h5E);
        do_op(1, 0, 8, 12, 8'h44);
        do_op(0, 1, D, 1, 8'h00);

        // Reset while the strobe is high, button kept held through reset.
        len_in  = 0;
        sw_data = 8'h5A;
        @(negedge clk_10KHz);
        predict(1, 0, D, 0, 8'h5A, cyc);
        btn_enq_raw = 1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_10KHz);
            if (enqueue_out) seen = 1;
        end
        check("rst_wait_strobe", int'(seen), 1);
        #2 reset = 1;
        #1;
        check("mid_rst_enq", int'(enqueue_out), 0);
        check("mid_rst_data", int'(data_out), 0);
        check("mid_rst_flags", int'({err_full, err_empty}), 0);
        m_data = 0;
        m_ef = 0;
        m_ee = 0;
        exp_q.delete();
        repeat (3) @(negedge clk_10KHz);
        reset = 0;
        repeat (30) @(negedge clk_10KHz);
        btn_enq_raw = 0;
        repeat (D + 8) @(negedge clk_10KHz);
        do_op(1, 0, 6, 2, 8'h77);

        for (int i = 0; i < 40; i++) begin
            int sel, hold;
            sel  = $urandom_range(0, 3);
            hold = (sel == 3) ? $urandom_range(1, D - 1)
                              : $urandom_range(D, D + 12);
            do_op(sel != 1, sel == 1 || sel == 2, hold,
                  8'($urandom_range(0, 10)), 8'($urandom));
        end

        repeat (5) @(negedge clk_10KHz);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
